poly_decompress_stream: RTL and testbench

POLY_DECOMPRESS_STREAM -- requirements
Module: poly_decompress_stream

---
 rtl/poly_decompress_stream_if.sv | 27 ++
 rtl/poly_decompress_stream.sv | 154 +++++++++++++++
 tb/tb_poly_decompress_stream.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/poly_decompress_stream_if.sv
// Stream bundle for poly_decompress_stream.
//   in_*  : 32-bit packed-bit words into the decompressor (valid/ready)
//   out_* : LANES coefficients per beat out of the decompressor (valid/ready/last)
// The slave modport is the decompressor's view; the master modport is the
// view of whoever feeds words in and drains beats out.
interface poly_decompress_stream_if #(
  parameter int LANES   = 2,
  parameter int COEFF_W = 16
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [31:0]              in_data_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [LANES*COEFF_W-1:0] out_data_o;
  logic                     out_last_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/poly_decompress_stream.sv
// Streaming polynomial decompressor.
// Unpacks N d-bit fields (LSB-first from 32-bit words) and maps each x to
// round(x*Q / 2^d), emitting LANES coefficients per registered output beat.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   start_i, d_i    start pulse and compression width (legal: 1,4,5,10,11)
//   busy_o          high in RUN and DONE
//   done_o          one-cycle pulse after the last beat handshake
//   err_o           one-cycle pulse for start with an illegal d_i
//   s               word input / coefficient output streams (slave view)

// One lane: x -> (x*Q + 2^(d-1)) >> d at 23-bit width.
module poly_decompress_lane #(
  parameter int Q       = 3329,
  parameter int COEFF_W = 16
) (
  input  logic [3:0]         d,
  input  logic [10:0]        x,
  output logic [COEFF_W-1:0] coeff
);
  logic [22:0] prod;
  logic [22:0] res;
  // d is 0 only outside RUN, where the result is never loaded.
  assign prod  = 23'(x) * 23'(Q) + (23'd1 << (d - 4'd1));
  assign res   = prod >> d;
  assign coeff = COEFF_W'(res);
endmodule

module poly_decompress_stream #(
  parameter int Q       = 3329,
  parameter int N       = 256,
  parameter int LANES   = 2,
  parameter int COEFF_W = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] d_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  poly_decompress_stream_if.slave s
);
  localparam int IN_W   = 32;
  localparam int BUF_W  = IN_W + LANES*11;
  localparam int FILL_W = $clog2(BUF_W+1);
  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = $clog2(BEATS+1);
  localparam int WORD_W = $clog2(N*11/32+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state_q, state_d;
  logic [3:0]                      d_q;
  logic [BUF_W-1:0]                buf_q, buf_rem, buf_nxt;
  logic [FILL_W-1:0]               fill_q, fill_rem, fill_nxt, sh_amt;
  logic [WORD_W-1:0]               words_q, words_total;
  logic [BEAT_W-1:0]               beats_q;
  logic                            out_valid_q, out_last_q, err_q;
  logic [LANES-1:0][COEFF_W-1:0]   out_data_q, lane_coeff;
  logic                            legal_d, in_rdy, accept, load, start_ok;

  assign legal_d     = d_i inside {4'd1, 4'd4, 4'd5, 4'd10, 4'd11};
  assign start_ok    = (state_q == IDLE) && start_i && legal_d;
  assign sh_amt      = FILL_W'(d_q) * FILL_W'(LANES);
  assign words_total = WORD_W'((N/32) * d_q);

  // Only admit a word while the whole 32 bits fit above the current fill.
  assign in_rdy = (state_q == RUN) && (words_q < words_total) &&
                  (fill_q <= FILL_W'(BUF_W - IN_W));
  assign accept = in_rdy && s.in_valid_i;
  assign load   = (state_q == RUN) && (beats_q < BEAT_W'(BEATS)) &&
                  (fill_q >= sh_amt) && (!out_valid_q || s.out_ready_i);

  // Consume first, then append the new word above the remainder so a field
  // straddling a word boundary is stitched together without gaps.
  always_comb begin
    buf_rem  = load ? (buf_q >> sh_amt) : buf_q;
    fill_rem = load ? (fill_q - sh_amt) : fill_q;
    buf_nxt  = buf_rem;
    fill_nxt = fill_rem;
    if (accept) begin
      buf_nxt  = buf_rem | (BUF_W'(s.in_data_i) << fill_rem);
      fill_nxt = fill_rem + FILL_W'(IN_W);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [10:0] raw, x;
    assign raw = 11'(buf_q >> (FILL_W'(k) * FILL_W'(d_q)));
    assign x   = raw & ((11'd1 << d_q) - 11'd1);
    poly_decompress_lane #(.Q(Q), .COEFF_W(COEFF_W)) u_lane (
      .d(d_q), .x(x), .coeff(lane_coeff[k])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (out_valid_q && s.out_ready_i && out_last_q) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      d_q         <= '0;
      buf_q       <= '0;
      fill_q      <= '0;
      words_q     <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start_i && !legal_d;
      if (start_ok) begin
        d_q         <= d_i;
        buf_q       <= '0;
        fill_q      <= '0;
        words_q     <= '0;
        beats_q     <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        buf_q  <= buf_nxt;
        fill_q <= fill_nxt;
        if (accept) words_q <= words_q + WORD_W'(1);
        if (load) begin
          out_data_q  <= lane_coeff;
          out_valid_q <= 1'b1;
          out_last_q  <= (beats_q == BEAT_W'(BEATS-1));
          beats_q     <= beats_q + BEAT_W'(1);
        end else if (s.out_ready_i) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign err_o         = err_q;
  assign s.in_ready_o  = in_rdy;
  assign s.out_valid_o = out_valid_q;
  assign s.out_last_o  = out_last_q;
  assign s.out_data_o  = out_data_q;
endmodule

// File: tb/tb_poly_decompress_stream.sv
module tb_poly_decompress_stream;
  localparam int N = 256, LANES = 2, COEFF_W = 16, Q = 3329, BEATS = N/LANES;

  logic clk_i = 1'b0, rst_ni = 1'b0, start_i = 1'b0;
  logic [3:0] d_i = 4'd0;
  logic busy_o, done_o, err_o;

  poly_decompress_stream_if #(.LANES(LANES), .COEFF_W(COEFF_W)) bus ();

  poly_decompress_stream #(.Q(Q), .N(N), .LANES(LANES), .COEFF_W(COEFF_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .d_i(d_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .s(bus)
  );

  always #5 clk_i = ~clk_i;

  int npass = 0, ntot = 0;
  logic [31:0] words [0:87];
  int exp_coef [0:N-1];
  int nwords, cur_d, wacc, bi, cyc = 0, done_pend, stall_lo = -1, acc_cyc, ov_cyc;
  logic op_done, op_active = 1'b0, hold_v, saw_full;
  logic [LANES*COEFF_W-1:0] held, first_beat;

  task automatic chk(input string nm, input longint act, input longint req);
    ntot++;
    if (act == req) npass++;
    else $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
  endtask

  // Reference: concatenate words LSB-first, cut d-bit fields, round(x*Q/2^d).
  function automatic int model_coef(input int d, input int x);
    return int'((longint'(x) * Q + (longint'(1) << (d-1))) >> d);
  endfunction

  task automatic build_expect();
    for (int i = 0; i < N; i++) begin
      int x = 0;
      for (int j = 0; j < cur_d; j++) begin
        int p = i*cur_d + j;
        logic [31:0] w = words[p/32];
        if (w[p%32]) x |= (1 << j);
      end
      exp_coef[i] = model_coef(cur_d, x);
    end
  endtask

  // Compare process body, runs once per cycle on the falling edge.
  task automatic monitor();
    logic [LANES*COEFF_W-1:0] e;
    cyc++;
    if (!rst_ni) return;
    if (done_pend == 1) begin
      chk("done_pulse", done_o, 1);
      chk("busy_in_done", busy_o, 1);
      chk("in_ready_done", bus.in_ready_o, 0);
      done_pend = 2;
    end else if (done_pend == 2) begin
      chk("done_clear", done_o, 0);
      chk("busy_idle", busy_o, 0);
      done_pend = 0;
      op_done = 1'b1;
    end
    if (hold_v) begin
      chk("hold_valid", bus.out_valid_o, 1);
      chk("hold_data", bus.out_data_o, held);
    end
    if (bus.in_valid_i && bus.in_ready_o) begin
      if (wacc == 0) acc_cyc = cyc;
      wacc++;
      if (wacc > nwords) chk("extra_word", wacc, nwords);
    end
    if (bus.out_valid_o && ov_cyc < 0) ov_cyc = cyc;
    if (bus.out_valid_o && bus.out_ready_i) begin
      if (bi >= BEATS) chk("extra_beat", bi, BEATS - 1);
      else begin
        for (int k = 0; k < LANES; k++) e[k*COEFF_W +: COEFF_W] = COEFF_W'(exp_coef[bi*LANES + k]);
        chk("beat_data", bus.out_data_o, e);
        chk("beat_last", bus.out_last_o, (bi == BEATS-1));
        if (bi == 0) first_beat = bus.out_data_o;
        bi++;
        if (bi == BEATS) done_pend = 1;
      end
    end
    hold_v = bus.out_valid_o && !bus.out_ready_i;
    held   = bus.out_data_o;
    if (!bus.out_ready_i && busy_o && !bus.in_ready_o && wacc < nwords) saw_full = 1'b1;
  endtask

  task automatic drive();
    bus.in_valid_i  = op_active;
    bus.in_data_i   = (wacc < nwords) ? words[wacc] : 32'hDEADBEEF;
    bus.out_ready_i = !(stall_lo >= 0 && cyc >= stall_lo && cyc < stall_lo + 10);
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    drive();
  endtask

  task automatic all_zero(input string nm);
    chk(nm, {busy_o, done_o, err_o, bus.in_ready_o, bus.out_valid_o, bus.out_last_o,
             bus.out_data_o}, 0);
  endtask

  task automatic run_op(input int d, input int nw, input int stall, input int abort_at,
                        input int restart_at);
    cur_d = d; nwords = nw; build_expect();
    wacc = 0; bi = 0; done_pend = 0; op_done = 1'b0; hold_v = 1'b0; saw_full = 1'b0;
    acc_cyc = -1; ov_cyc = -1; first_beat = '0;
    start_i = 1'b1; d_i = 4'(d); op_active = 1'b1;
    stall_lo = (stall >= 0) ? cyc + stall : -1;
    drive();
    tick();
    start_i = 1'b0; d_i = 4'd0;
    for (int t = 0; t < 4000 && !op_done; t++) begin
      if (abort_at >= 0 && bi >= abort_at) begin
        rst_ni = 1'b0;
        #1;
        all_zero("reset_async_outputs");
        op_active = 1'b0; stall_lo = -1;
        drive();
        repeat (3) @(posedge clk_i);
        #1;
        all_zero("reset_held_outputs");
        rst_ni = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", {busy_o, bus.out_valid_o, bus.in_ready_o}, 0);
        return;
      end
      if (t == restart_at) begin start_i = 1'b1; d_i = 4'd1; end
      else begin start_i = 1'b0; d_i = 4'd0; end
      tick();
    end
    start_i = 1'b0; d_i = 4'd0; op_active = 1'b0; stall_lo = -1;
    drive();
    chk("op_completed", op_done, 1);
    chk("words_accepted", wacc, nwords);
    chk("beats_emitted", bi, BEATS);
    chk("first_beat_latency", ov_cyc - acc_cyc, 2);
  endtask

  initial begin
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    all_zero("reset_state");
    rst_ni = 1'b1;
    repeat (2) tick();
    chk("idle_after_release", busy_o, 0);

    // d=1, all ones: every coefficient is 1665
    for (int i = 0; i < 88; i++) words[i] = 32'hFFFF_FFFF;
    run_op(1, 8, -1, -1, -1);
    chk("lit_d1_ones", first_beat, {16'd1665, 16'd1665});

    // d=1, single set bit
    for (int i = 0; i < 88; i++) words[i] = 32'h0;
    words[0] = 32'h0000_0001;
    run_op(1, 8, -1, -1, -1);
    chk("lit_d1_bit0", first_beat, {16'd0, 16'd1665});

    // d=4: lane0 x=8, lane1 x=15
    words[0] = 32'h0000_00F8;
    run_op(4, 32, -1, -1, -1);
    chk("lit_d4_f8", first_beat, {16'd3121, 16'd1665});

    // d=11 all ones: fields straddle word boundaries
    for (int i = 0; i < 88; i++) words[i] = 32'hFFFF_FFFF;
    run_op(11, 88, -1, -1, -1);
    chk("lit_d11_ones", first_beat, {16'd3327, 16'd3327});

    // d=5 random with 10-cycle output stall
    for (int i = 0; i < 88; i++) words[i] = $urandom;
    run_op(5, 40, 20, -1, -1);
    chk("stall_backpressure", saw_full, 1);

    // d=10 random with a stray start mid-run that must be ignored
    for (int i = 0; i < 88; i++) words[i] = $urandom;
    run_op(10, 80, -1, -1, 30);

    // illegal d
    start_i = 1'b1; d_i = 4'd3;
    tick();
    start_i = 1'b0; d_i = 4'd0;
    chk("err_pulse", err_o, 1);
    chk("err_busy", busy_o, 0);
    tick();
    chk("err_clear", err_o, 0);
    chk("err_still_idle", busy_o, 0);

    // reset at beat 40, then a clean restart
    for (int i = 0; i < 88; i++) words[i] = $urandom;
    run_op(1, 8, -1, 40, -1);
    run_op(1, 8, -1, -1, -1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
